wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters: the pipeline writeback stage (PL) and the multicycle multdiv completion path (MD).
- Drives the per-register write enables of the 32 x 32-bit enabled-flop register bank, plus one shared write-data bus.
- Gives PL fixed priority, holds the MD result in a one-entry buffer, and uses a starvation guard to force MD through after a bounded wait.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_decode.sv | 27 ++
 rtl/wb_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   - wb_state_e : arbiter FSM states (NORMAL, FORCE_MD)
//   - AW_DEF / NREG_DEF / DW : default address width, register count, data width
//   - R0         : index of the hardwired-zero register
//   - CNT_W      : width of the MD starvation wait counter (limit up to 15)
//   - wait_hits(): true when the wait counter would step onto its limit
package wb_pkg;

    localparam int AW_DEF   = 5;
    localparam int NREG_DEF = 32;
    localparam int DW       = 32;
    localparam int R0       = 0;
    localparam int CNT_W    = 4;

    localparam logic [CNT_W-1:0] CNT_ONE = 4'd1;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_MD = 1'b1
    } wb_state_e;

    // The force decision is taken on the edge where the counter would
    // increment onto the limit, so compare the incremented value.
    function automatic logic wait_hits(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] limit);
        return ((cnt + CNT_ONE) == limit);
    endfunction

endpackage

// File: rtl/wb_decode.sv
// Combinational register-address to one-hot write-enable decoder.
// Ports:
//   en     in  1     decode enable (a write is granted this cycle)
//   addr   in  AW    destination register
//   onehot out NREG  one-hot enable; all-zero when disabled or addr is r0
module wb_decode
    import wb_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic            en,
    input  logic [AW-1:0]   addr,
    output logic [NREG-1:0] onehot
);

    // One-hot decode with r0 masked off: r0 is hardwired, never written.
    always_comb begin
        onehot = '0;
        if (en && (addr != AW'(R0))) begin
            onehot[addr] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the pipeline
// writeback stage (PL, fixed priority) and the multdiv completion path (MD).
// MD results wait in a one-entry hold buffer; after MD_MAX_WAIT consecutive
// lost arbitrations the FSM forces one MD grant by stalling PL for a cycle.
// Optional build macro: WB_BYPASS_EN adds byp_valid/byp_addr/byp_data.
// Ports:
//   clk, clr                   clock, synchronous active-high reset
//   pl_valid/pl_rd/pl_data     PL write request;   pl_ready = accepted
//   md_valid/md_rd/md_data     MD result;          md_ready = buffer empty
//   rf_we                      registered one-hot write enable (NREG bits)
//   rf_waddr/rf_wdata          registered write address / data
//   byp_valid/byp_addr/byp_data  (WB_BYPASS_EN) mirror of the current write
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int MD_MAX_WAIT = 4,
    parameter int NREG        = NREG_DEF,
    parameter int AW          = AW_DEF
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            pl_valid,
    input  logic [AW-1:0]   pl_rd,
    input  logic [DW-1:0]   pl_data,
    output logic            pl_ready,
    input  logic            md_valid,
    input  logic [AW-1:0]   md_rd,
    input  logic [DW-1:0]   md_data,
    output logic            md_ready,
    output logic [NREG-1:0] rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [DW-1:0]   rf_wdata
`ifdef WB_BYPASS_EN
    ,
    output logic            byp_valid,
    output logic [AW-1:0]   byp_addr,
    output logic [DW-1:0]   byp_data
`endif
);

    localparam logic [CNT_W-1:0] MAX_WAIT = CNT_W'(MD_MAX_WAIT);

    wb_state_e         state_r;
    wb_state_e         state_s;
    logic              hold_valid_r;
    logic [AW-1:0]     hold_rd_r;
    logic [DW-1:0]     hold_data_r;
    logic [CNT_W-1:0]  wait_r;
    logic [CNT_W-1:0]  wait_s;
    logic              grant_pl_s;
    logic              grant_md_s;
    logic              grant_s;
    logic [AW-1:0]     gnt_rd_s;
    logic [DW-1:0]     gnt_data_s;
    logic [NREG-1:0]   dec_s;

    // Both handshakes depend only on registered state, never on the valids.
    assign pl_ready = (state_r == NORMAL);
    assign md_ready = !hold_valid_r;

    // Arbitration and next-state: PL first in NORMAL, buffer only in FORCE_MD.
    always_comb begin
        state_s    = state_r;
        grant_pl_s = 1'b0;
        grant_md_s = 1'b0;
        case (state_r)
            NORMAL: begin
                if (pl_valid) begin
                    grant_pl_s = 1'b1;
                end else if (hold_valid_r) begin
                    grant_md_s = 1'b1;
                end else begin
                    grant_md_s = 1'b0;
                end
                if (hold_valid_r && !grant_md_s && wait_hits(wait_r, MAX_WAIT)) begin
                    state_s = FORCE_MD;
                end else begin
                    state_s = NORMAL;
                end
            end
            FORCE_MD: begin
                grant_md_s = hold_valid_r;
                state_s    = NORMAL;
            end
            default: begin
                state_s = NORMAL;
            end
        endcase
    end

    // Starvation counter: counts consecutive losses of a buffered MD result.
    always_comb begin
        wait_s = '0;
        if (hold_valid_r && !grant_md_s) begin
            wait_s = wait_r + CNT_ONE;
        end else begin
            wait_s = '0;
        end
    end

    // Select the winning request's address and data.
    always_comb begin
        grant_s    = grant_pl_s | grant_md_s;
        gnt_rd_s   = hold_rd_r;
        gnt_data_s = hold_data_r;
        if (grant_pl_s) begin
            gnt_rd_s   = pl_rd;
            gnt_data_s = pl_data;
        end else begin
            gnt_rd_s   = hold_rd_r;
            gnt_data_s = hold_data_r;
        end
    end

    wb_decode #(
        .AW   (AW),
        .NREG (NREG)
    ) u_decode (
        .en     (grant_s),
        .addr   (gnt_rd_s),
        .onehot (dec_s)
    );

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= NORMAL;
            wait_r  <= '0;
        end else begin
            state_r <= state_s;
            wait_r  <= wait_s;
        end
    end

    // MD hold buffer: a drain and a new capture never share an edge,
    // because capture is only allowed while the buffer is already empty.
    always_ff @(posedge clk) begin
        if (clr) begin
            hold_valid_r <= 1'b0;
            hold_rd_r    <= '0;
            hold_data_r  <= '0;
        end else if (grant_md_s) begin
            hold_valid_r <= 1'b0;
        end else if (md_valid && !hold_valid_r) begin
            hold_valid_r <= 1'b1;
            hold_rd_r    <= md_rd;
            hold_data_r  <= md_data;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end

    // Registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (clr) begin
            rf_we    <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= dec_s;
            if (grant_s) begin
                rf_waddr <= gnt_rd_s;
                rf_wdata <= gnt_data_s;
            end else begin
                rf_waddr <= rf_waddr;
                rf_wdata <= rf_wdata;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding view of the write currently presented to the bank.
    assign byp_valid = |rf_we;
    assign byp_addr  = rf_waddr;
    assign byp_data  = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        pl_valid = 1'b0;
    logic [4:0]  pl_rd = 5'd0;
    logic [31:0] pl_data = 32'd0;
    logic        pl_ready;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic [31:0] rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_addr;
    logic [31:0] byp_data;
`endif

    wb_port_arbiter #(.MD_MAX_WAIT(MAXW), .NREG(32), .AW(5)) dut (
        .clk      (clk),
        .clr      (clr),
        .pl_valid (pl_valid),
        .pl_rd    (pl_rd),
        .pl_data  (pl_data),
        .pl_ready (pl_ready),
        .md_valid (md_valid),
        .md_rd    (md_rd),
        .md_data  (md_data),
        .md_ready (md_ready),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid (byp_valid),
        .byp_addr  (byp_addr),
        .byp_data  (byp_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: what is waiting, how often it has lost,
    // whether PL is being stalled this cycle, and what the port last wrote.
    bit          m_init = 1'b0;
    bit          m_hold = 1'b0;
    logic [4:0]  m_hold_rd = 5'd0;
    logic [31:0] m_hold_data = 32'd0;
    int          m_losses = 0;
    bit          m_stall = 1'b0;
    logic [4:0]  m_waddr = 5'd0;
    logic [31:0] m_wdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the write produced by the coming edge and advance the model.
    task automatic model_step(input bit c, input bit pv, input logic [4:0] pr,
                              input logic [31:0] pd, input bit mv,
                              input logic [4:0] mr, input logic [31:0] md);
        wr_t e;
        bit  pl_wins;
        bit  md_wins;
        e.we = 32'd0;
        if (c) begin
            m_init = 1'b1; m_hold = 1'b0; m_losses = 0; m_stall = 1'b0;
            m_waddr = 5'd0; m_wdata = 32'd0;
        end else if (m_init) begin
            pl_wins = pv && !m_stall;
            md_wins = m_hold && (m_stall || !pv);
            if (pl_wins) begin
                m_waddr = pr; m_wdata = pd;
            end else if (md_wins) begin
                m_waddr = m_hold_rd; m_wdata = m_hold_data;
            end
            if ((pl_wins || md_wins) && m_waddr != 5'd0) e.we[m_waddr] = 1'b1;
            if (m_hold && !md_wins) begin
                m_losses = m_losses + 1;
                m_stall  = !m_stall && (m_losses == MAXW);
            end else begin
                m_losses = 0;
                m_stall  = 1'b0;
            end
            if (md_wins) m_hold = 1'b0;
            else if (!m_hold && mv) begin
                m_hold = 1'b1; m_hold_rd = mr; m_hold_data = md;
            end
        end
        e.addr = m_waddr;
        e.data = m_wdata;
        if (m_init) exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, check the handshakes, queue the expectation.
    task automatic cycle(input bit c, input bit pv, input logic [4:0] pr,
                         input logic [31:0] pd, input bit mv,
                         input logic [4:0] mr, input logic [31:0] md);
        @(negedge clk);
        clr = c; pl_valid = pv; pl_rd = pr; pl_data = pd;
        md_valid = mv; md_rd = mr; md_data = md;
        #1;
        if (m_init) begin
            chk("pl_ready", {31'd0, pl_ready}, {31'd0, !m_stall});
            chk("md_ready", {31'd0, md_ready}, {31'd0, !m_hold});
        end
        model_step(c, pv, pr, pd, mv, mr, md);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Monitor: pop one expected write after each edge and compare the port.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we", rf_we, e.we);
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.addr});
                chk("rf_wdata", rf_wdata, e.data);
`ifdef WB_BYPASS_EN
                chk("byp_valid", {31'd0, byp_valid}, {31'd0, (e.we != 32'd0)});
                chk("byp_addr", {27'd0, byp_addr}, {27'd0, e.addr});
                chk("byp_data", byp_data, e.data);
`endif
            end
        end
    end

    initial begin
        int guard;
        // Reset
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        idle(1);
        // PL write to r5
        cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        idle(2);
        // MD result to r3 with PL idle
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h12345678);
        idle(3);
        // Continuous PL traffic while an MD result waits: forced slot
        cycle(1'b0, 1'b1, 5'd9, 32'h00000900, 1'b1, 5'd7, 32'h77777777);
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, 5'(10 + i), 32'h00001000 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(2);
        // PL write to r0 is consumed but never enables a register
        cycle(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'd0);
        idle(2);
        // Reset while in FORCE_MD with a buffered result
        cycle(1'b0, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd6, 32'h66666666);
        guard = 0;
        while (!m_stall && guard < 20) begin
            cycle(1'b0, 1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'd0);
            guard++;
        end
        cycle(1'b1, 1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'd0);
        idle(3);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
        end
        idle(4);
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
